mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
// Byte-serial RAM controller between the 8-bit unified memory port and the core.
// Serves two masters: LoadStoreBuffer (loads/stores, 1/2/4 B) and instruction fetch (4 B words).
// Runs one transaction at a time. Assembles and sign/zero-extends load data. Aborts speculative reads on rollback.
// PARAMETERS
// ADDR_WIDTH   32     address width of all address ports
// IO_SEL_LSB   16     addr[IO_SEL_LSB+1:IO_SEL_LSB]==2'b11 marks the IO region
// PORTS
// clk            in   1   clock
// rst            in   1   reset, synchronous, active-high
// rdy            in   1   global enable; low = freeze all state
// rollback       in   1   pipeline flush pulse
// mem_din        in   8   RAM read byte (for address driven previous cycle)
// mem_dout       out  8   RAM write byte
// mem_a          out  32  RAM byte address
// mem_wr         out  1   1 = write mem_dout to mem_a this cycle
// io_buffer_full in   1   IO sink cannot take a byte
// lsb_req_valid  in   1   LSB request
// lsb_req_store  in   1   1 = store, 0 = load
// lsb_req_size   in   2   0 byte, 1 half, 2/3 word
// lsb_req_signed in   1   sign-extend load result
// lsb_req_addr   in   32  byte address
// lsb_req_wdata  in   32  store data, little-endian
// lsb_ready      out  1   controller idle; LSB request accepted when valid&ready
// lsb_done       out  1   one-cycle completion pulse (load or store)
// lsb_rdata      out  32  extended load data, valid with lsb_done
// if_req_valid   in   1   fetch request
// if_req_addr    in   32  fetch address
// if_ready       out  1   fetch request accepted when valid&ready
// if_done        out  1   one-cycle fetch completion pulse
// if_rdata       out  32  fetched instruction, valid with if_done
// BEHAVIOUR
// - Reset: state IDLE, cnt=0, mem_wr=0, mem_a=0, mem_dout=0, *_done=0, *_rdata=0, last_grant=IF.
// - rdy=0: no state/counter/output-register change; mem_wr forced 0.
// - States: IDLE, READ, WRITE. N = 1/2/4 bytes per size; fetch N=4.
// - IDLE: ready outputs high.
//   - Grant to LSB if only LSB valid. Grant to IF if only IF valid.
//   - If both valid, the master NOT granted last wins (alternation).
//   - Grant latches addr/size/signed/wdata/master, cnt=0, and moves to READ or WRITE.
//   - Exactly one ready is effectively honoured per cycle: the losing master's ready is low in that cycle.
// - READ cycle k (k=1..N+1 after accept):
//   - For k<=N: mem_a=base+k-1, mem_wr=0.
//   - For k>=2: mem_din is captured as byte k-2.
//   - After cycle N+1: go IDLE; the master's done=1 in the next cycle with rdata.
//   - Load latency = N+2 cycles from accept to done.
// - Load extension: byte [7:0] / half [15:0] sign- or zero-extended per signed; word unchanged.
// - WRITE cycle k (k=1..N): mem_a=base+k-1, mem_wr=1, mem_dout=wdata byte k-1.
//   - lsb_done is asserted in cycle N+1 (back in IDLE).
// - IO stall: if the write target is IO and io_buffer_full=1, mem_wr=0 and cnt holds; resume when clear.
// - A new request may be accepted in the same IDLE cycle that done pulses.
// - Address arithmetic wraps mod 2^32. No alignment check; unaligned accesses are byte-serial and legal.
// - rollback=1:
//   - READ (load or fetch) aborts to IDLE next cycle with no done pulse.
//   - WRITE (committed store) continues to completion.
//   - In IDLE, no load/fetch is granted that cycle; a store request is still granted.
// - done pulses are never asserted for two consecutive cycles for the same transaction.
// TESTING
// - Fetch at 0x100, RAM bytes 13 05 00 00 -> mem_a 0x100..0x103 in cycles 1-4; if_done in cycle 6, if_rdata=0x00000513.
// - Signed byte load at 0x20 holding 0x80 -> lsb_rdata=0xFFFFFF80. Unsigned load -> 0x00000080. Done at +3.
// - Half store 0xBEEF to 0x40 -> mem_wr cycles 1-2, (0x40,EF),(0x41,BE); lsb_done in cycle 3.
// - LSB and IF valid together twice in a row -> first grant alternates from last_grant; second grant goes to the other master.
// - Word load, rollback in cycle 3 -> IDLE next cycle, no lsb_done. Same with a store -> store completes and lsb_done pulses.
// - Byte store to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr low 5 cycles, then one write; rdy=0 mid-load -> no progress.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: every signal between mem_ctrl and its surroundings except
// clk/rst. It carries the global controls (rdy, rollback), the byte-wide
// unified RAM port with the IO back-pressure flag, the LoadStoreBuffer
// request/response channel and the instruction-fetch request/response channel.
//   slave  : the controller side (mem_ctrl)
//   master : the core / RAM environment side
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  // global controls
  logic                  rdy;
  logic                  rollback;
  // unified RAM port
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;
  // LoadStoreBuffer channel
  logic                  lsb_req_valid;
  logic                  lsb_req_store;
  logic [1:0]            lsb_req_size;
  logic                  lsb_req_signed;
  logic [ADDR_WIDTH-1:0] lsb_req_addr;
  logic [31:0]           lsb_req_wdata;
  logic                  lsb_ready;
  logic                  lsb_done;
  logic [31:0]           lsb_rdata;
  // instruction-fetch channel
  logic                  if_req_valid;
  logic [ADDR_WIDTH-1:0] if_req_addr;
  logic                  if_ready;
  logic                  if_done;
  logic [31:0]           if_rdata;

  modport slave (
    input  rdy, rollback, mem_din, io_buffer_full,
    input  lsb_req_valid, lsb_req_store, lsb_req_size, lsb_req_signed,
    input  lsb_req_addr, lsb_req_wdata, if_req_valid, if_req_addr,
    output mem_dout, mem_a, mem_wr,
    output lsb_ready, lsb_done, lsb_rdata, if_ready, if_done, if_rdata
  );

  modport master (
    output rdy, rollback, mem_din, io_buffer_full,
    output lsb_req_valid, lsb_req_store, lsb_req_size, lsb_req_signed,
    output lsb_req_addr, lsb_req_wdata, if_req_valid, if_req_addr,
    input  mem_dout, mem_a, mem_wr,
    input  lsb_ready, lsb_done, lsb_rdata, if_ready, if_done, if_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller shared by the LoadStoreBuffer and
// instruction fetch. One transaction runs at a time. Loads and fetches are
// assembled little-endian from the byte port and extended; stores are emitted
// one byte per cycle. A rollback kills an in-flight read but never a store.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : mem_ctrl_if.slave (controls, RAM port, LSB and fetch channels)
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_SEL_LSB = 16
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  localparam logic M_LSB = 1'b0;
  localparam logic M_IF  = 1'b1;

  state_t                r_state;
  logic [2:0]            r_cnt;        // READ: cycle index-1; WRITE: byte index
  logic [1:0]            r_last;       // bytes in transaction minus one
  logic                  r_master;     // owner of the current read
  logic                  r_last_grant;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [7:0]            r_mem_dout;
  logic                  r_wr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_buf;
  logic                  r_lsb_done;
  logic                  r_if_done;
  logic [31:0]           r_lsb_rdata;
  logic [31:0]           r_if_rdata;

  logic                  w_idle;
  logic                  w_lsb_ok;
  logic                  w_if_ok;
  logic                  w_grant_lsb;
  logic                  w_grant_if;
  logic                  w_io_stall;
  logic [2:0]            w_cnt_nx;
  logic [1:0]            w_idx;
  logic [ADDR_WIDTH-1:0] w_next_a;
  logic [31:0]           w_asm;
  logic [31:0]           w_ext;
  logic [1:0]            w_req_last;

  // Arbitration. A load/fetch is not eligible while rollback is high, a store
  // always is. When both masters are eligible the one not served last wins.
  assign w_idle      = (r_state == S_IDLE) && bus.rdy;
  assign w_lsb_ok    = bus.lsb_req_valid && (bus.lsb_req_store || !bus.rollback);
  assign w_if_ok     = bus.if_req_valid && !bus.rollback;
  assign w_grant_lsb = w_idle && w_lsb_ok && (!w_if_ok || (r_last_grant == M_IF));
  assign w_grant_if  = w_idle && w_if_ok && (!w_lsb_ok || (r_last_grant == M_LSB));

  // ready is the grant qualified without the requester's own valid, so that
  // valid & ready is exactly the grant and the loser sees ready low.
  assign bus.lsb_ready = w_idle && (bus.lsb_req_store || !bus.rollback)
                         && !(w_if_ok && (r_last_grant == M_LSB));
  assign bus.if_ready  = w_idle && !bus.rollback
                         && !(w_lsb_ok && (r_last_grant == M_IF));

  // A write to the IO window waits while the IO sink is full.
  assign w_io_stall = (r_mem_a[IO_SEL_LSB+1:IO_SEL_LSB] == 2'b11) && bus.io_buffer_full;

  assign w_cnt_nx   = r_cnt + 3'd1;
  assign w_idx      = r_cnt[1:0] - 2'd1;
  assign w_next_a   = r_base + ADDR_WIDTH'(w_cnt_nx);
  assign w_req_last = (bus.lsb_req_size == 2'd0) ? 2'd0 :
                      (bus.lsb_req_size == 2'd1) ? 2'd1 : 2'd3;

  // Read data arriving this cycle belongs to the address driven last cycle,
  // i.e. byte r_cnt-1; merge it so the final cycle can extend in one go.
  always_comb begin
    w_asm = r_buf;
    if (r_cnt != 3'd0) w_asm[{w_idx, 3'b000} +: 8] = bus.mem_din;
    case (r_size)
      2'd0:    w_ext = {{24{r_signed & w_asm[7]}}, w_asm[7:0]};
      2'd1:    w_ext = {{16{r_signed & w_asm[15]}}, w_asm[15:0]};
      default: w_ext = w_asm;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_last       <= 2'd0;
      r_master     <= M_LSB;
      r_last_grant <= M_IF;
      r_size       <= 2'd0;
      r_signed     <= 1'b0;
      r_base       <= '0;
      r_mem_a      <= '0;
      r_mem_dout   <= 8'd0;
      r_wr         <= 1'b0;
      r_wdata      <= 32'd0;
      r_buf        <= 32'd0;
      r_lsb_done   <= 1'b0;
      r_if_done    <= 1'b0;
      r_lsb_rdata  <= 32'd0;
      r_if_rdata   <= 32'd0;
    end else if (bus.rdy) begin
      r_lsb_done <= 1'b0;
      r_if_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_lsb) begin
            r_cnt        <= 3'd0;
            r_buf        <= 32'd0;
            r_last_grant <= M_LSB;
            r_master     <= M_LSB;
            r_base       <= bus.lsb_req_addr;
            r_mem_a      <= bus.lsb_req_addr;
            r_size       <= bus.lsb_req_size;
            r_signed     <= bus.lsb_req_signed;
            r_wdata      <= bus.lsb_req_wdata;
            r_mem_dout   <= bus.lsb_req_wdata[7:0];
            r_last       <= w_req_last;
            if (bus.lsb_req_store) begin
              r_state <= S_WRITE;
              r_wr    <= 1'b1;
            end else begin
              r_state <= S_READ;
            end
          end else if (w_grant_if) begin
            r_cnt        <= 3'd0;
            r_buf        <= 32'd0;
            r_last_grant <= M_IF;
            r_master     <= M_IF;
            r_base       <= bus.if_req_addr;
            r_mem_a      <= bus.if_req_addr;
            r_size       <= 2'd2;
            r_signed     <= 1'b0;
            r_last       <= 2'd3;
            r_state      <= S_READ;
          end
        end

        S_READ: begin
          if (bus.rollback) begin
            r_state <= S_IDLE;
          end else begin
            if (r_cnt != 3'd0) r_buf <= w_asm;
            if (w_cnt_nx <= {1'b0, r_last}) r_mem_a <= w_next_a;
            // one extra cycle after the last address to catch its data
            if (r_cnt == ({1'b0, r_last} + 3'd1)) begin
              r_state <= S_IDLE;
              if (r_master == M_IF) begin
                r_if_done  <= 1'b1;
                r_if_rdata <= w_ext;
              end else begin
                r_lsb_done  <= 1'b1;
                r_lsb_rdata <= w_ext;
              end
            end
            r_cnt <= w_cnt_nx;
          end
        end

        S_WRITE: begin
          // stores are committed, so rollback is ignored here
          if (!w_io_stall) begin
            if (r_cnt[1:0] == r_last) begin
              r_state    <= S_IDLE;
              r_wr       <= 1'b0;
              r_lsb_done <= 1'b1;
            end else begin
              r_cnt      <= w_cnt_nx;
              r_mem_a    <= w_next_a;
              r_mem_dout <= r_wdata[{w_cnt_nx[1:0], 3'b000} +: 8];
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_a     = r_mem_a;
  assign bus.mem_dout  = r_mem_dout;
  assign bus.mem_wr    = r_wr && bus.rdy && !w_io_stall;
  assign bus.lsb_done  = r_lsb_done;
  assign bus.lsb_rdata = r_lsb_rdata;
  assign bus.if_done   = r_if_done;
  assign bus.if_rdata  = r_if_rdata;

endmodule
